branch_ctrl: RTL and testbench

Branch resolution controller for the pipelined ARM-subset CPU. It holds the architectural N/Z flag register and resolves B, BL, CBZ and B.cond instructions in the ID stage. It drives PC-select, pipeline stall and IF/ID flush, and keeps saturating branch statistics counters. It sequences the condition-decode function so that a B.cond never reads flags that are still being produced in EX.

---
 rtl/branch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_branch_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// branch_ctrl
// Branch resolution controller for the ID stage. Owns the architectural N/Z
// flags, resolves B / BL / CBZ / B.cond, drives PC-select (take), pipeline
// stall and IF/ID flush, and keeps saturating branch statistics.
//
// State table:
//   IDLE       | normal operation; resolves branches with no flag hazard
//   WAIT_FLAGS | one stall cycle elapsed; resolve held B.cond on new flags
//   SQUASH     | flush the wrong-path instruction fetched after a taken branch
//
// Ports:
//   clk, reset_n               clock, async active-low reset
//   flag_we, ex_neg, ex_zero   flag write from EX stage
//   br_valid, br_type, br_cond branch in ID (type: 00 B, 01 BL, 10 CBZ, 11 B.cond)
//   cbz_zero                   CBZ operand is zero
//   clr_counts                 synchronous clear of statistics counters
//   take, stall, flush         pipeline control
//   br_done, link_we           branch resolved / BL link write
//   flag_n, flag_z             architectural flags
//   br_count, taken_count      saturating statistics counters
module branch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flag_we,
  input  logic             ex_neg,
  input  logic             ex_zero,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [4:0]       br_cond,
  input  logic             cbz_zero,
  input  logic             clr_counts,
  output logic             take,
  output logic             stall,
  output logic             flush,
  output logic             br_done,
  output logic             link_we,
  output logic             flag_n,
  output logic             flag_z,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FLAGS,
    SQUASH
  } state_t;

  localparam logic [1:0] TYPE_B     = 2'b00;
  localparam logic [1:0] TYPE_BL    = 2'b01;
  localparam logic [1:0] TYPE_CBZ   = 2'b10;
  localparam logic [1:0] TYPE_BCOND = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_nxt;
  logic [3:0] held_cond;

  // Unlisted condition codes are never taken.
  function automatic logic cond_holds(input logic [3:0] code, input logic n, input logic z);
    logic r;
    case (code)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b1010: r = ~n;
      4'b1011: r = n;
      4'b1100: r = ~n & ~z;
      4'b1101: r = n | z;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
    end else if (flag_we) begin
      flag_n <= ex_neg;
      flag_z <= ex_zero;
    end
  end

  // The condition is captured on the stall cycle so the resolve in
  // WAIT_FLAGS does not depend on ID still presenting the same field.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_cond <= 4'b0000;
    end else if (stall) begin
      held_cond <= br_cond[3:0];
    end
  end

  // stall and flush never depend on take, so there is no path from the
  // branch outcome back into the hazard decode.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    br_done   = 1'b0;
    link_we   = 1'b0;
    case (state)
      IDLE: begin
        if (br_valid) begin
          if (br_type == TYPE_BCOND && flag_we) begin
            stall     = 1'b1;
            state_nxt = WAIT_FLAGS;
          end else begin
            br_done = 1'b1;
            case (br_type)
              TYPE_B, TYPE_BL: take = 1'b1;
              TYPE_CBZ:        take = cbz_zero;
              default:         take = cond_holds(br_cond[3:0], flag_n, flag_z);
            endcase
            link_we   = (br_type == TYPE_BL);
            state_nxt = take ? SQUASH : IDLE;
          end
        end
      end
      WAIT_FLAGS: begin
        br_done   = 1'b1;
        take      = cond_holds(held_cond, flag_n, flag_z);
        state_nxt = take ? SQUASH : IDLE;
      end
      SQUASH: begin
        flush     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (clr_counts) begin
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      if (br_done && br_count != CNT_MAX) begin
        br_count <= br_count + CNT_W'(1);
      end
      if (take && taken_count != CNT_MAX) begin
        taken_count <= taken_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl. The driver pushes the hand-derived expected
// outputs of every cycle it drives; a monitor pops and compares at the
// falling edge. Counters use CNT_W=8 so saturation is reachable quickly.
module tb_branch_ctrl;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flag_we = 1'b0, ex_neg = 1'b0, ex_zero = 1'b0;
  logic             br_valid = 1'b0;
  logic [1:0]       br_type = 2'b00;
  logic [4:0]       br_cond = 5'd0;
  logic             cbz_zero = 1'b0, clr_counts = 1'b0;
  logic             take, stall, flush, br_done, link_we, flag_n, flag_z;
  logic [CNT_W-1:0] br_count, taken_count;

  branch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .flag_we(flag_we), .ex_neg(ex_neg),
    .ex_zero(ex_zero), .br_valid(br_valid), .br_type(br_type),
    .br_cond(br_cond), .cbz_zero(cbz_zero), .clr_counts(clr_counts),
    .take(take), .stall(stall), .flush(flush), .br_done(br_done),
    .link_we(link_we), .flag_n(flag_n), .flag_z(flag_z),
    .br_count(br_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             take, stall, flush, done, link, fn, fz;
    logic [CNT_W-1:0] bc, tc;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle_tag = 0;

  logic             m_n = 1'b0, m_z = 1'b0;
  logic [CNT_W-1:0] m_bc = '0, m_tc = '0;

  function automatic obs_t sample();
    obs_t o;
    o = '{take, stall, flush, br_done, link_we, flag_n, flag_z, br_count, taken_count};
    return o;
  endfunction

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got take=%b stall=%b flush=%b done=%b link=%b n=%b z=%b bc=%0d tc=%0d, required take=%b stall=%b flush=%b done=%b link=%b n=%b z=%b bc=%0d tc=%0d",
               name, act.take, act.stall, act.flush, act.done, act.link, act.fn, act.fz, act.bc, act.tc,
               exp.take, exp.stall, exp.flush, exp.done, exp.link, exp.fn, exp.fz, exp.bc, exp.tc);
    end
  endtask

  // Monitor: each driven cycle has exactly one expected record.
  always @(negedge clk) begin
    if (reset_n && exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      compare($sformatf("cycle%0d", cycle_tag), sample(), e);
      cycle_tag++;
    end
  end

  // Drive one cycle of inputs with the hand-derived control outputs; flags
  // and counters expected are those registered before this cycle.
  task automatic cyc(input logic v, input logic [1:0] t, input logic [4:0] c,
                     input logic cz, input logic fwe, input logic n, input logic z,
                     input logic clr, input logic e_take, input logic e_stall,
                     input logic e_flush, input logic e_done, input logic e_link);
    obs_t e;
    @(posedge clk);
    #1;
    br_valid = v; br_type = t; br_cond = c; cbz_zero = cz;
    flag_we = fwe; ex_neg = n; ex_zero = z; clr_counts = clr;
    e = '{e_take, e_stall, e_flush, e_done, e_link, m_n, m_z, m_bc, m_tc};
    exp_q.push_back(e);
    if (fwe) begin
      m_n = n;
      m_z = z;
    end
    if (clr) begin
      m_bc = '0;
      m_tc = '0;
    end else begin
      if (e_done && m_bc != CNT_MAX) m_bc = m_bc + 1'b1;
      if (e_take && m_tc != CNT_MAX) m_tc = m_tc + 1'b1;
    end
  endtask

  task automatic idle(input logic e_flush);
    cyc(0, 2'b00, 5'd0, 0, 0, 0, 0, 0, 0, 0, e_flush, 0, 0);
  endtask

  task automatic set_flags(input logic n, input logic z);
    cyc(0, 2'b00, 5'd0, 0, 1, n, z, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending records, required 0", exp_q.size());
    end
  endtask

  logic [3:0] codes [6] = '{4'b0000, 4'b0001, 4'b1010, 4'b1011, 4'b1100, 4'b1101};
  // Bit index is {N,Z}; value is whether the condition is taken.
  logic [3:0] tbl   [6] = '{4'b1010, 4'b0101, 4'b0011, 4'b1100, 4'b0001, 4'b1110};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t zero_obs;
    logic t;
    zero_obs = '0;

    #3;
    compare("reset_values", sample(), zero_obs);
    #10;
    reset_n = 1'b1;

    idle(0);

    // Flag hazard: B.cond EQ with a concurrent Z-setting instruction.
    cyc(1, 2'b11, 5'b00000, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    cyc(1, 2'b11, 5'b00000, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    idle(1);
    idle(0);

    // Condition sweep.
    for (int nz = 0; nz < 4; nz++) begin
      set_flags(nz[1], nz[0]);
      for (int k = 0; k < 6; k++) begin
        t = tbl[k][nz];
        cyc(1, 2'b11, {1'b0, codes[k]}, 0, 0, 0, 0, 0, t, 0, 0, 1, 0);
        if (t) idle(1);
      end
      cyc(1, 2'b11, 5'b10111, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    end
    // Bit 4 ignored: flags N=1,Z=1 so 1_0000 acts as EQ and is taken.
    cyc(1, 2'b11, 5'b10000, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    idle(1);

    // BL, then CBZ not-taken and taken.
    cyc(1, 2'b01, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    idle(1);
    cyc(1, 2'b10, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(0);
    cyc(1, 2'b10, 5'd0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    idle(1);

    // Wrong-path branch presented during SQUASH is ignored.
    cyc(1, 2'b00, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    cyc(1, 2'b00, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0);

    // flag_we during WAIT_FLAGS does not change the resolution in progress.
    cyc(1, 2'b11, 5'b00000, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    cyc(1, 2'b11, 5'b00000, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0);
    cyc(0, 2'b00, 5'd0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0);

    // Not-taken hazard resolve: NE with Z=1 after stall, no flush.
    cyc(1, 2'b11, 5'b00001, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    cyc(1, 2'b11, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(0);

    // Saturation: clear, then 2^CNT_W taken branches.
    cyc(0, 2'b00, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < (1 << CNT_W); i++) begin
      cyc(1, 2'b00, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
      idle(1);
    end
    idle(0);
    drain();
    checks++;
    if (br_count !== CNT_MAX || taken_count !== CNT_MAX) begin
      failures++;
      $display("FAIL saturation: got bc=%0d tc=%0d, required %0d", br_count, taken_count, CNT_MAX);
    end
    // Clear wins over a concurrent taken branch.
    cyc(1, 2'b00, 5'd0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    idle(1);
    idle(0);

    // Reset in the middle of WAIT_FLAGS.
    cyc(1, 2'b11, 5'b00000, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    drain();
    @(posedge clk);
    #1;
    br_valid = 0; br_type = 2'b00; br_cond = 5'd0; flag_we = 0;
    ex_neg = 0; ex_zero = 0; clr_counts = 0; cbz_zero = 0;
    reset_n = 1'b0;
    m_n = 0; m_z = 0; m_bc = '0; m_tc = '0;
    #1;
    compare("reset_mid_wait", sample(), zero_obs);
    #1;
    reset_n = 1'b1;
    idle(0);
    idle(0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
